// File: rtl/dtr_sample_scheduler.sv
// Purpose: schedules DTR sensor conversions (periodic or oneshot) behind a small register window.
// Latency: register reads return one clock after the address; start pulse 1 clock after a request is seen in IDLE.
// Backpressure: none; every bus cycle is accepted, and oneshots requested while busy merge into one pending request.
module dtr_sample_scheduler #(
    parameter int BaseAddress    = 0,
    parameter int address_width  = 16,
    parameter int data_width     = 8,
    parameter int PRESCALE       = 1000,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [address_width-1:0] address_i,
    input  logic [data_width-1:0]    data_i,
    output logic [data_width-1:0]    data_o,
    input  logic                     rd_wr_i,
    output logic                     start_pulse_o,
    input  logic [7:0]               dtr_i,
    output logic                     busy_o,
    output logic                     alarm_o
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [address_width-1:0] A_CTRL   = address_width'(BaseAddress + 0);
    localparam logic [address_width-1:0] A_PERIOD = address_width'(BaseAddress + 1);
    localparam logic [address_width-1:0] A_STATUS = address_width'(BaseAddress + 2);
    localparam logic [address_width-1:0] A_LAST   = address_width'(BaseAddress + 3);
    localparam logic [address_width-1:0] A_THRESH = address_width'(BaseAddress + 4);
    localparam logic [address_width-1:0] A_MAX    = address_width'(BaseAddress + 5);

    typedef enum logic [2:0] {
        IDLE, WAIT_PERIOD, START, ARM, CONVERT, CAPTURE
    } state_t;

    state_t          state_q, state_d;
    logic            enable_q, pending_q, alarm_q, timeout_q, new_sample_q;
    logic [7:0]      period_q;
    logic [5:0]      thresh_q, last_code_q, max_code_q, code_q;
    logic [PW-1:0]   pre_cnt;
    logic [7:0]      tick_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic [7:0]      eff_period, rd_val;
    logic            tmo_expire, conv_hit, capture;
    logic            wr_ctrl, alarm_clr, rd_last;
    logic            unused_dtr_bit;

    // Bit 6 of the sensor word carries nothing we use.
    assign unused_dtr_bit = dtr_i[6];

    assign wr_ctrl    = rd_wr_i && (address_i == A_CTRL);
    assign alarm_clr  = wr_ctrl && data_i[2];
    assign rd_last    = !rd_wr_i && (address_i == A_LAST);
    assign capture    = (state_q == CAPTURE);
    assign eff_period = (period_q == 8'd0) ? 8'd1 : period_q;

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; a pending oneshot always preempts the period wait.
    always_comb begin
        state_d    = state_q;
        tmo_expire = 1'b0;
        conv_hit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending_q)     state_d = START;
                else if (enable_q) state_d = WAIT_PERIOD;
            end
            WAIT_PERIOD: begin
                if (pending_q)                                              state_d = START;
                else if (!enable_q)                                         state_d = IDLE;
                else if (pre_cnt == PRE_LAST && tick_cnt == eff_period - 8'd1) state_d = START;
            end
            START: state_d = ARM;
            ARM: begin
                // Wait for the sensor to drop valid so a stale result is never taken.
                if (!dtr_i[7]) state_d = CONVERT;
                else if (tmo_cnt == '0) begin
                    state_d    = IDLE;
                    tmo_expire = 1'b1;
                end
            end
            CONVERT: begin
                if (dtr_i[7]) begin
                    state_d  = CAPTURE;
                    conv_hit = 1'b1;
                end else if (tmo_cnt == '0) begin
                    state_d    = IDLE;
                    tmo_expire = 1'b1;
                end
            end
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Period prescaler/tick counters and the conversion timeout counter.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pre_cnt  <= '0;
            tick_cnt <= 8'd0;
            tmo_cnt  <= '0;
        end else begin
            if (state_q == WAIT_PERIOD) begin
                if (pre_cnt == PRE_LAST) begin
                    pre_cnt  <= '0;
                    tick_cnt <= tick_cnt + 8'd1;
                end else begin
                    pre_cnt <= pre_cnt + PW'(1);
                end
            end else begin
                pre_cnt  <= '0;
                tick_cnt <= 8'd0;
            end
            if (state_q == START)
                tmo_cnt <= TMO_LAST;
            else if ((state_q == ARM || state_q == CONVERT) && tmo_cnt != '0)
                tmo_cnt <= tmo_cnt - TW'(1);
        end
    end

    // Control registers, pending oneshot and timeout flag.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            enable_q  <= 1'b0;
            pending_q <= 1'b0;
            period_q  <= 8'h10;
            thresh_q  <= 6'd63;
            timeout_q <= 1'b0;
        end else begin
            if (wr_ctrl) enable_q <= data_i[0];
            if (rd_wr_i && address_i == A_PERIOD) period_q <= data_i[7:0];
            if (rd_wr_i && address_i == A_THRESH) thresh_q <= data_i[5:0];
            if (wr_ctrl && data_i[1])  pending_q <= 1'b1;
            else if (state_q == START) pending_q <= 1'b0;
            if (tmo_expire)   timeout_q <= 1'b1;
            else if (wr_ctrl) timeout_q <= 1'b0;
        end
    end

    // Sample results: code latch, last/max code, new_sample and sticky alarm.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            code_q       <= 6'd0;
            last_code_q  <= 6'd0;
            max_code_q   <= 6'd0;
            new_sample_q <= 1'b0;
            alarm_q      <= 1'b0;
        end else begin
            if (conv_hit) code_q <= dtr_i[5:0];
            if (capture) last_code_q <= code_q;
            if (capture)      new_sample_q <= 1'b1;
            else if (rd_last) new_sample_q <= 1'b0;
            // A clear followed by a same-cycle capture leaves the new code as max.
            if (alarm_clr)                          max_code_q <= capture ? code_q : 6'd0;
            else if (capture && code_q > max_code_q) max_code_q <= code_q;
            if (capture && code_q >= thresh_q) alarm_q <= 1'b1;
            else if (alarm_clr)                 alarm_q <= 1'b0;
        end
    end

    // Read mux; unmapped addresses read as zero.
    always_comb begin
        rd_val = 8'h00;
        if (address_i == A_CTRL)        rd_val = {7'd0, enable_q};
        else if (address_i == A_PERIOD) rd_val = period_q;
        else if (address_i == A_STATUS) rd_val = {4'd0, new_sample_q, timeout_q, alarm_q, busy_o};
        else if (address_i == A_LAST)   rd_val = {2'b00, last_code_q};
        else if (address_i == A_THRESH) rd_val = {2'b00, thresh_q};
        else if (address_i == A_MAX)    rd_val = {2'b00, max_code_q};
    end

    // Registered outputs: start pulse and busy track the state being entered.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            start_pulse_o <= 1'b0;
            busy_o        <= 1'b0;
            data_o        <= '0;
        end else begin
            start_pulse_o <= (state_d == START);
            busy_o        <= (state_d == START) || (state_d == ARM) ||
                             (state_d == CONVERT) || (state_d == CAPTURE);
            if (!rd_wr_i) data_o <= data_width'(rd_val);
        end
    end

    assign alarm_o = alarm_q;

endmodule
